// File: rtl/muldiv_hilo_writer.sv
// Iterative multiply/divide unit that produces the Hi/Lo register write.
// One operand bit is processed per RUN cycle: shift-add for MULT/MULTU and
// restoring division for DIV/DIVU. Signed ops work on magnitudes, and the
// signs are applied in FIX. The result is presented in WRITE with one-cycle
// HiLE/LoLE enables. HiOut/LoOut hold their value until the next result.
module muldiv_hilo_writer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic             HiLE,
  output logic             LoLE,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivZero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [CW-1:0]      CNT_LOAD = CW'(ITER - 1);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   W_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]     X_ZERO   = {(WIDTH+1){1'b0}};
  localparam logic [2*WIDTH-1:0] P_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Unsigned magnitude of an operand; 0x80000000 maps to +2^31 without overflow.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
    logic [WIDTH:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = {1'b0, ~v + W_ONE};
    end else begin
      m = {1'b0, v};
    end
    return m;
  endfunction

  // State and latched operands
  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             neg_q, neg_d;      // quotient/product must be negated
  logic             rneg_q, rneg_d;    // remainder takes a negative sign
  // Working registers: rem = product high / partial remainder,
  // quo = multiplier / quotient bits, dvs = multiplicand / divisor.
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Output registers
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dz_q, dz_d, busy_q, busy_d;

  logic             is_signed_s, is_div_s;
  logic [WIDTH:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic             div_ge_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
  logic             fix_dz_s;

  assign is_signed_s = ~op_q[0];
  assign is_div_s    = op_q[1];
  assign mag_a_s     = magnitude(a_q, is_signed_s);
  assign mag_b_s     = magnitude(b_q, is_signed_s);
  assign mul_sum_s   = rem_q + (quo_q[0] ? dvs_q : X_ZERO);
  assign div_shift_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= dvs_q);
  assign div_diff_s  = div_shift_s - dvs_q;
  assign prod_s      = {rem_q[WIDTH-1:0], quo_q};

  // Final result selection: sign fix-up, divide-by-zero override, Hi/Lo mapping
  always_comb begin
    fix_hi_s = W_ZERO;
    fix_lo_s = W_ZERO;
    fix_dz_s = 1'b0;
    if (!is_div_s) begin
      if (neg_q) begin
        {fix_hi_s, fix_lo_s} = ~prod_s + P_ONE;
      end else begin
        {fix_hi_s, fix_lo_s} = prod_s;
      end
    end else if (b_q == W_ZERO) begin
      fix_hi_s = a_q;
      fix_lo_s = W_ONES;
      fix_dz_s = 1'b1;
    end else begin
      fix_lo_s = neg_q  ? (~quo_q + W_ONE) : quo_q;
      fix_hi_s = rneg_q ? (~rem_q[WIDTH-1:0] + W_ONE) : rem_q[WIDTH-1:0];
    end
  end

  // Next-state and datapath control for the IDLE/PREP/RUN/FIX/WRITE sequence
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Cancel) begin
          state_d = S_IDLE;
        end else if (Start) begin
          op_d    = Op;
          a_d     = A;
          b_d     = B;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (Cancel) begin
          state_d = S_IDLE;
        end else begin
          neg_d  = is_signed_s & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d = is_signed_s & a_q[WIDTH-1];
          rem_d  = X_ZERO;
          cnt_d  = CNT_LOAD;
          if (is_div_s) begin
            quo_d = mag_a_s[WIDTH-1:0];
            dvs_d = mag_b_s;
          end else begin
            quo_d = mag_b_s[WIDTH-1:0];
            dvs_d = mag_a_s;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (Cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_s) begin
            rem_d = div_ge_s ? div_diff_s : div_shift_s;
            quo_d = {quo_q[WIDTH-2:0], div_ge_s};
          end else begin
            rem_d = {1'b0, mul_sum_s[WIDTH:1]};
            quo_d = {mul_sum_s[0], quo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_ZERO) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_FIX: begin
        if (Cancel) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = fix_hi_s;
          lo_d    = fix_lo_s;
          dz_d    = fix_dz_s;
          done_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, working and output registers with asynchronous clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= W_ZERO;
      b_q     <= W_ZERO;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      rem_q   <= X_ZERO;
      quo_q   <= W_ZERO;
      dvs_q   <= X_ZERO;
      cnt_q   <= CNT_ZERO;
      hi_q    <= W_ZERO;
      lo_q    <= W_ZERO;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign HiLE    = done_q;
  assign LoLE    = done_q;
  assign DivZero = dz_q;
  assign HiOut   = hi_q;
  assign LoOut   = lo_q;

endmodule
